lane_deser: RTL and testbench
=============================

# lane_deser

Serial-to-parallel front end that assembles two W-bit lanes, `cc_out` then `bb_out`, from a 1-bit input stream. It presents the pair to the downstream lane-merge register stage with a valid/ready handshake. It sits directly upstream of the lane-merge stage and drives that stage's `cc` and `bb` byte inputs. Both lanes use descending-index-free `[0:W-1]` ordering: the first bit received lands in index 0.

## Interface
- `W`, default 8: lane width in bits; legal range 2..32.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sin` input 1: serial data bit.
- `sin_valid` input 1: `sin` is presented this cycle.
- `cc_out` output [0:W-1]: first assembled lane (bits 0..W-1 of a frame).
- `bb_out` output [0:W-1]: second assembled lane (bits W..2W-1 of a frame).
- `pair_valid` output 1: `cc_out`/`bb_out` hold a complete frame.
- `pair_ready` input 1: downstream accepts the pair this cycle.
- `ovf` output 1: sticky flag; a bit was dropped because a frame was still held.

## Operation
- FSM states:
  - FILL_CC: collecting the first lane.
  - FILL_BB: collecting the second lane.
  - HOLD: full frame presented.
- Bit counter `cnt` is $clog2(W) bits wide and counts accepted bits within the current lane.
- FILL_CC, on `sin_valid`:
  - `cc_out[cnt] <= sin`; `cnt` increments.
  - When `cnt == W-1`: `cnt <= 0`, go to FILL_BB.
- FILL_BB, on `sin_valid`:
  - `bb_out[cnt] <= sin`; `cnt` increments.
  - When `cnt == W-1`: `cnt <= 0`, `pair_valid <= 1`, go to HOLD.
- HOLD:
  - `cc_out`, `bb_out` and `pair_valid` are frozen until a handshake (`pair_valid && pair_ready`).
  - Handshake without `sin_valid`: `pair_valid <= 0`, go to FILL_CC.
  - Handshake with `sin_valid` in the same cycle: the pair is consumed, `cc_out[0] <= sin`, `cnt <= 1`, go to FILL_CC. No bit is lost.
  - `sin_valid` without handshake: the bit is discarded and `ovf <= 1`.
- `ovf` is cleared only by `rst`.
- A cycle with `sin_valid == 0` leaves all state unchanged.
- Each output bit has exactly one driver: a single sequential process owns `cc_out`, `bb_out`, `pair_valid`, `ovf`, `cnt` and the state register.
- Lane bits that have not yet been written in the current frame keep their previous frame's values. Only complete frames are meaningful downstream.

## Timing
- Reset values: `cc_out = 0`, `bb_out = 0`, `pair_valid = 0`, `ovf = 0`, state FILL_CC, `cnt = 0`.
- Reset mid-frame: the partial frame is discarded and all of the above values are restored on the next edge. A held pair is dropped without handshake.
- Latency: `pair_valid` is high in the cycle after the edge that captures accepted bit 2W. With gap-free input, the first `pair_valid` appears 2W cycles after the first `sin_valid`.
- Sustained throughput: one frame per 2W accepted bits with no bubble, provided `pair_ready` is high in the first HOLD cycle.
- `pair_ready` is ignored outside HOLD.
- No combinational path from any input to any output; all outputs are registered.

## Structure
- Shared package `lane_pkg`:
  - `LANE_W_DEFAULT = 8`.
  - Enum `lane_state_t {FILL_CC, FILL_BB, HOLD}`.
- No sub-module is required.
- Optional split: a single-driver `lane_shift` capture register (index-addressed write, enable), instantiated twice. The FSM and `ovf` stay in `lane_deser`.

## Test plan
- Reset, then stream 16 bits `1,0,1,1,0,0,0,1, 1,1,0,0,1,0,1,0` with `pair_ready = 1` -> one cycle after the 16th bit: `cc_out = 8'b1011_0001` (index 0 first), `bb_out = 8'b1100_1010`, `pair_valid = 1`; `pair_valid = 0` on the next cycle.
- `pair_ready = 0` for 5 cycles in HOLD with `sin_valid = 0` -> outputs unchanged for all 5 cycles; `ovf = 0`.
- In HOLD with `pair_ready = 0`, drive 3 `sin_valid` bits -> `ovf = 1` and stays 1. The next frame starts only with bits sent after the handshake.
- Handshake and `sin_valid` (`sin = 1`) in the same cycle -> the pair is consumed, state FILL_CC, `cc_out[0] = 1`, `cnt = 1`. The following 15 bits complete a correct frame.
- Assert `rst` after 11 accepted bits -> the next edge shows all reset values. A fresh 16-bit stream yields a correct frame with no residue from the aborted one.
- Random `sin_valid` gaps (about 50% duty) over 100 frames with random `pair_ready` -> the scoreboard sees frame order and contents match the input, with drops only where `ovf` rose.

Source files
------------

// File: rtl/lane_pkg.sv
// Shared definitions for the lane deserialiser: default lane width and FSM states.
package lane_pkg;

    localparam int LANE_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        FILL_CC = 2'd0,
        FILL_BB = 2'd1,
        HOLD    = 2'd2
    } lane_state_t;

endpackage

// File: rtl/lane_deser.sv
// Serial-to-parallel front end: collects 2*W bits into the cc/bb lane pair
// (first bit into index 0) and offers the pair downstream with valid/ready.
module lane_deser
    import lane_pkg::*;
#(
    parameter int W = LANE_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_valid,
    input  logic         pair_ready,
    output logic [0:W-1] cc_out,
    output logic [0:W-1] bb_out,
    output logic         pair_valid,
    output logic         ovf
);

    localparam int            CW      = $clog2(W);
    localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    lane_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [0:W-1]  cc_q, cc_d;
    logic [0:W-1]  bb_q, bb_d;
    logic          pv_q, pv_d;
    logic          ovf_q, ovf_d;

    // Next-state logic: bit capture, lane sequencing, handshake and overflow detection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cc_d    = cc_q;
        bb_d    = bb_q;
        pv_d    = pv_q;
        ovf_d   = ovf_q;

        case (state_q)
            FILL_CC: begin
                if (sin_valid) begin
                    cc_d[cnt_q] = sin;
                    if (cnt_q == CNT_MAX) begin
                        cnt_d   = {CW{1'b0}};
                        state_d = FILL_BB;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            FILL_BB: begin
                if (sin_valid) begin
                    bb_d[cnt_q] = sin;
                    if (cnt_q == CNT_MAX) begin
                        cnt_d   = {CW{1'b0}};
                        pv_d    = 1'b1;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end

            HOLD: begin
                if (pair_ready) begin
                    // Pair consumed; a bit arriving in the same cycle starts the next frame.
                    pv_d    = 1'b0;
                    state_d = FILL_CC;
                    if (sin_valid) begin
                        cc_d[0] = sin;
                        cnt_d   = CNT_ONE;
                    end else begin
                        cnt_d = {CW{1'b0}};
                    end
                end else begin
                    // Frame still held: any arriving bit has nowhere to go.
                    if (sin_valid) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                end
            end

            default: begin
                state_d = FILL_CC;
                cnt_d   = {CW{1'b0}};
                pv_d    = 1'b0;
            end
        endcase
    end

    // State, counter, lane and flag registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL_CC;
            cnt_q   <= {CW{1'b0}};
            cc_q    <= {W{1'b0}};
            bb_q    <= {W{1'b0}};
            pv_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cc_q    <= cc_d;
            bb_q    <= bb_d;
            pv_q    <= pv_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cc_out     = cc_q;
    assign bb_out     = bb_q;
    assign pair_valid = pv_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_lane_deser.sv
// Self-checking bench for lane_deser: directed frames with literal expectations
// plus a frame-level reference model compared against the DUT every cycle.
module tb_lane_deser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic         sin_valid;
    logic         pair_ready;
    logic [0:W-1] cc_out;
    logic [0:W-1] bb_out;
    logic         pair_valid;
    logic         ovf;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    lane_deser #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .pair_ready (pair_ready),
        .cc_out     (cc_out),
        .bb_out     (bb_out),
        .pair_valid (pair_valid),
        .ovf        (ovf)
    );

    // ---------------- reference model ----------------
    // Frame view: accepted bits of the frame in progress, expected lane contents,
    // whether a complete frame is being held, and the sticky drop flag.
    bit           m_bits[$];
    logic [0:W-1] m_cc;
    logic [0:W-1] m_bb;
    logic         m_pv;
    logic         m_ovf;
    int           m_frames = 0;
    int           m_drops  = 0;
    bit           done     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int pos;
        if (rst) begin
            m_bits.delete();
            m_cc  = '0;
            m_bb  = '0;
            m_pv  = 1'b0;
            m_ovf = 1'b0;
        end else if (m_pv) begin
            if (pair_ready) begin
                m_pv = 1'b0;
                m_frames++;
                if (sin_valid) begin
                    m_bits.push_back(sin);
                    m_cc[0] = sin;
                end
            end else if (sin_valid) begin
                m_ovf = 1'b1;
                m_drops++;
            end
        end else if (sin_valid) begin
            pos = m_bits.size();
            if (pos < W) m_cc[pos] = sin;
            else         m_bb[pos - W] = sin;
            m_bits.push_back(sin);
            if (m_bits.size() == 2 * W) begin
                m_pv = 1'b1;
                m_bits.delete();
            end
        end
    endtask

    // Model advances on each rising edge; DUT outputs are compared on the falling edge.
    initial begin
        while (!done) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (!done) begin
                check("pair_valid", 32'(pair_valid), 32'(m_pv));
                check("ovf",        32'(ovf),        32'(m_ovf));
                check("cc_out",     32'(cc_out),     32'(m_cc));
                check("bb_out",     32'(bb_out),     32'(m_bb));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input logic v, input logic s, input logic r);
        @(negedge clk);
        sin_valid  = v;
        sin        = s;
        pair_ready = r;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] f, input logic r);
        for (int i = 15; i >= 0; i--) begin
            tick(1'b1, f[i], r);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [15:0] fa;
        logic [15:0] fb;
        logic [15:0] fc;
        logic [15:0] fe;
        logic [15:0] ff;
        int start;
        int cyc;

        fa = 16'b1011_0001_1100_1010;
        fb = 16'hA53C;
        fc = 16'h0FF0;
        fe = 16'b1110_0100_0101_1001;
        ff = 16'h6D92;

        rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; pair_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cc",  32'(cc_out),     32'h0);
        check("rst_bb",  32'(bb_out),     32'h0);
        check("rst_pv",  32'(pair_valid), 32'h0);
        check("rst_ovf", 32'(ovf),        32'h0);
        rst = 1'b0;

        // Basic frame, pair_ready held high.
        send_frame(fa, 1'b1);
        after_edge();
        check("a_cc", 32'(cc_out),     32'(8'b1011_0001));
        check("a_bb", 32'(bb_out),     32'(8'b1100_1010));
        check("a_pv", 32'(pair_valid), 32'h1);
        tick(1'b0, 1'b0, 1'b1);
        after_edge();
        check("a_pv_drop", 32'(pair_valid), 32'h0);

        // Held frame with pair_ready low and no input: nothing moves.
        send_frame(fb, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            after_edge();
            check("b_hold_pv", 32'(pair_valid), 32'h1);
            check("b_hold_cc", 32'(cc_out),     32'(fb[15:8]));
            check("b_hold_bb", 32'(bb_out),     32'(fb[7:0]));
            check("b_hold_ovf", 32'(ovf),       32'h0);
        end

        // Bits arriving while held are dropped and raise ovf.
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        after_edge();
        check("b_ovf",     32'(ovf),    32'h1);
        check("b_keep_cc", 32'(cc_out), 32'(fb[15:8]));
        tick(1'b0, 1'b0, 1'b1);
        send_frame(fc, 1'b1);
        after_edge();
        check("c_cc",  32'(cc_out), 32'(fc[15:8]));
        check("c_bb",  32'(bb_out), 32'(fc[7:0]));
        check("c_ovf", 32'(ovf),    32'h1);

        // Handshake and a new bit in the same cycle.
        tick(1'b1, 1'b1, 1'b1);
        after_edge();
        check("e_pv0",  32'(pair_valid), 32'h0);
        check("e_cc0",  32'(cc_out[0]),  32'h1);
        for (int i = 14; i >= 0; i--) begin
            tick(1'b1, fe[i], 1'b1);
        end
        after_edge();
        check("e_cc", 32'(cc_out),     32'(fe[15:8]));
        check("e_bb", 32'(bb_out),     32'(fe[7:0]));
        check("e_pv", 32'(pair_valid), 32'h1);

        // Reset in the middle of a frame.
        tick(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) begin
            tick(1'b1, 1'(i % 3), 1'b1);
        end
        @(negedge clk);
        rst = 1'b1; sin_valid = 1'b0;
        after_edge();
        check("mid_rst_cc",  32'(cc_out),     32'h0);
        check("mid_rst_bb",  32'(bb_out),     32'h0);
        check("mid_rst_pv",  32'(pair_valid), 32'h0);
        check("mid_rst_ovf", 32'(ovf),        32'h0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(ff, 1'b1);
        after_edge();
        check("f_cc", 32'(cc_out),     32'(ff[15:8]));
        check("f_bb", 32'(bb_out),     32'(ff[7:0]));
        check("f_pv", 32'(pair_valid), 32'h1);

        // Random gaps and back-pressure over 100 frames.
        start = m_frames;
        cyc   = 0;
        while ((m_frames - start) < 100 && cyc < 20000) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0));
            cyc++;
        end
        after_edge();
        check("rand_frames_done", 32'((m_frames - start) >= 100), 32'h1);
        check("rand_ovf_vs_drops", 32'(ovf), 32'(m_drops > 0));

        done = 1'b1;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
